// File: rtl/output_writeback.sv
// Result write-back stage: takes coordinate-tagged accumulator beats from the
// convolution core and writes them to external memory in channel-innermost
// layout through a small FIFO, then reports end of layer.
module output_writeback #(
  parameter int ACCUMULATION_WIDTH = 32,
  parameter int EXT_MEM_HEIGHT     = 1 << 20,
  parameter int FEATURE_MAP_WIDTH  = 64,
  parameter int FEATURE_MAP_HEIGHT = 64,
  parameter int OUTPUT_NB_CHANNELS = 32,
  parameter int FIFO_DEPTH         = 4,
  localparam int ADDR_W = $clog2(EXT_MEM_HEIGHT),
  localparam int XW     = (FEATURE_MAP_WIDTH  > 1) ? $clog2(FEATURE_MAP_WIDTH)  : 1,
  localparam int YW     = (FEATURE_MAP_HEIGHT > 1) ? $clog2(FEATURE_MAP_HEIGHT) : 1,
  localparam int CW     = (OUTPUT_NB_CHANNELS > 1) ? $clog2(OUTPUT_NB_CHANNELS) : 1,
  localparam int TOTAL  = FEATURE_MAP_WIDTH * FEATURE_MAP_HEIGHT * OUTPUT_NB_CHANNELS,
  localparam int CNT_W  = $clog2(TOTAL + 1)
) (
  input  logic                          clk,
  input  logic                          rst_in,
  input  logic                          start,
  input  logic [ADDR_W-1:0]             base_addr,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [ACCUMULATION_WIDTH-1:0] in_data,
  input  logic [XW-1:0]                 in_x,
  input  logic [YW-1:0]                 in_y,
  input  logic [CW-1:0]                 in_ch,
  output logic                          mem_we,
  input  logic                          mem_ready,
  output logic [ADDR_W-1:0]             mem_addr,
  output logic [ACCUMULATION_WIDTH-1:0] mem_wdata,
  output logic                          busy,
  output logic                          done,
  output logic                          err,
  output logic [CNT_W-1:0]              written_count
);

  localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

  state_t                        state_q, state_d;
  logic                          done_d;
  logic [ADDR_W-1:0]             base_q;
  logic [CNT_W-1:0]              acc_cnt;
  logic [ADDR_W-1:0]             fifo_addr [FIFO_DEPTH];
  logic [ACCUMULATION_WIDTH-1:0] fifo_data [FIFO_DEPTH];
  logic [PW-1:0]                 wr_ptr, rd_ptr;
  logic [PW:0]                   occ;
  logic                          fifo_full, fifo_empty;
  logic                          accept, in_range, push, pop;
  logic [ADDR_W-1:0]             beat_addr;

  // Handshake, range check, address arithmetic and FIFO head presentation
  always_comb begin
    fifo_full  = (occ == (PW+1)'(FIFO_DEPTH));
    fifo_empty = (occ == '0);
    in_ready   = (state_q == RUN) && !fifo_full;
    accept     = in_valid && in_ready;
    in_range   = (32'(in_x)  < 32'(FEATURE_MAP_WIDTH))  &&
                 (32'(in_y)  < 32'(FEATURE_MAP_HEIGHT)) &&
                 (32'(in_ch) < 32'(OUTPUT_NB_CHANNELS));
    push       = accept && in_range;
    pop        = !fifo_empty && mem_ready;
    // Offset formed at 64 bits then truncated: the sum wraps modulo 2^ADDR_W
    beat_addr  = base_q + ADDR_W'((64'(in_y) * 64'(FEATURE_MAP_WIDTH) + 64'(in_x))
                                  * 64'(OUTPUT_NB_CHANNELS) + 64'(in_ch));
    mem_we     = !fifo_empty;
    mem_addr   = fifo_addr[rd_ptr];
    mem_wdata  = fifo_data[rd_ptr];
    busy       = (state_q != IDLE);
  end

  // Next-state logic and end-of-layer detection
  always_comb begin
    state_d = state_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE:    if (start) state_d = RUN;
      RUN:     if (accept && acc_cnt == CNT_W'(TOTAL - 1)) state_d = DRAIN;
      DRAIN: begin
        if (fifo_empty) begin
          done_d  = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State, counters, error flag and FIFO storage
  always_ff @(posedge clk) begin
    if (rst_in) begin
      state_q       <= IDLE;
      done          <= 1'b0;
      err           <= 1'b0;
      base_q        <= '0;
      acc_cnt       <= '0;
      written_count <= '0;
      wr_ptr        <= '0;
      rd_ptr        <= '0;
      occ           <= '0;
      for (int unsigned i = 0; i < FIFO_DEPTH; i++) begin
        fifo_addr[i] <= '0;
        fifo_data[i] <= '0;
      end
    end else begin
      state_q <= state_d;
      done    <= done_d;
      if (state_q == IDLE && start) begin
        base_q        <= base_addr;
        acc_cnt       <= '0;
        written_count <= '0;
        err           <= 1'b0;
      end else begin
        if (pop)                 written_count <= written_count + 1'b1;
        if (accept)              acc_cnt       <= acc_cnt + 1'b1;
        if (accept && !in_range) err           <= 1'b1;
      end
      if (push) begin
        fifo_addr[wr_ptr] <= beat_addr;
        fifo_data[wr_ptr] <= in_data;
        wr_ptr            <= wr_ptr + 1'b1;
      end
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      occ <= occ + (PW+1)'(push) - (PW+1)'(pop);
    end
  end

endmodule

// File: tb/tb_output_writeback.sv
// Bench for output_writeback: a full-size instance (64x64x32) and a small
// non-power-of-two instance (3x2x2), each shadowed by a queue-based model.
module tb_output_writeback;

  localparam int AW = 20;
  localparam int DW = 32;
  localparam longint AMASK = (64'd1 << AW) - 1;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [1:0]    start = '0, in_valid = '0, mem_ready = '0;
  logic [AW-1:0] base = '0;
  logic [DW-1:0] din = '0;
  logic [5:0]    in_x = '0, in_y = '0;
  logic [4:0]    in_ch = '0;
  logic [1:0]    rdy, we, busy, done, err;
  logic [AW-1:0] maddr [2];
  logic [DW-1:0] mdata [2];
  logic [17:0]   wc0;
  logic [3:0]    wc1;

  always #5 clk = ~clk;

  output_writeback #(
    .ACCUMULATION_WIDTH(32), .EXT_MEM_HEIGHT(1 << 20), .FEATURE_MAP_WIDTH(64),
    .FEATURE_MAP_HEIGHT(64), .OUTPUT_NB_CHANNELS(32), .FIFO_DEPTH(4)
  ) u_big (
    .clk(clk), .rst_in(rst), .start(start[0]), .base_addr(base),
    .in_valid(in_valid[0]), .in_ready(rdy[0]), .in_data(din),
    .in_x(in_x), .in_y(in_y), .in_ch(in_ch),
    .mem_we(we[0]), .mem_ready(mem_ready[0]), .mem_addr(maddr[0]), .mem_wdata(mdata[0]),
    .busy(busy[0]), .done(done[0]), .err(err[0]), .written_count(wc0)
  );

  output_writeback #(
    .ACCUMULATION_WIDTH(32), .EXT_MEM_HEIGHT(1 << 20), .FEATURE_MAP_WIDTH(3),
    .FEATURE_MAP_HEIGHT(2), .OUTPUT_NB_CHANNELS(2), .FIFO_DEPTH(4)
  ) u_small (
    .clk(clk), .rst_in(rst), .start(start[1]), .base_addr(base),
    .in_valid(in_valid[1]), .in_ready(rdy[1]), .in_data(din),
    .in_x(in_x[1:0]), .in_y(in_y[0:0]), .in_ch(in_ch[0:0]),
    .mem_we(we[1]), .mem_ready(mem_ready[1]), .mem_addr(maddr[1]), .mem_wdata(mdata[1]),
    .busy(busy[1]), .done(done[1]), .err(err[1]), .written_count(wc1)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string nm, input longint act, input longint exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic longint gw(input int s);  return s ? 3 : 64; endfunction
  function automatic longint gh(input int s);  return s ? 2 : 64; endfunction
  function automatic longint goc(input int s); return s ? 2 : 32; endfunction

  // mem_ready pattern per instance: 0 low, 1 high, 2 random, 3 toggling
  int mr_mode [2] = '{0, 0};
  always @(posedge clk) begin
    #1;
    for (int s = 0; s < 2; s++) begin
      case (mr_mode[s])
        0: mem_ready[s] = 1'b0;
        1: mem_ready[s] = 1'b1;
        2: mem_ready[s] = 1'($urandom_range(0, 1));
        default: mem_ready[s] = ~mem_ready[s];
      endcase
    end
  end

  // ---------------- reference model ----------------
  typedef struct packed { logic [AW-1:0] a; logic [DW-1:0] d; } wr_t;
  wr_t    expq [2][$];
  int     mode [2]    = '{0, 0};   // 0 idle, 1 collecting, 2 flushing
  longint acc [2]     = '{0, 0};
  longint wcnt [2]    = '{0, 0};
  longint basem [2]   = '{0, 0};
  bit     errm [2]    = '{0, 0};
  bit     donem [2]   = '{0, 0};
  bit     postrst [2] = '{0, 0};
  int     ndone [2]   = '{0, 0};
  bit     mon_en = 0;

  always @(negedge clk) begin
    for (int s = 0; s < 2; s++) begin
      int     m0;
      bit     exp_rdy, done_n;
      longint x, y, c, wc_act;
      m0      = mode[s];
      exp_rdy = (m0 == 1) && (expq[s].size() < 4);
      wc_act  = s ? longint'(wc1) : longint'(wc0);
      if (mon_en) begin
        chk($sformatf("in_ready[%0d]", s), rdy[s], exp_rdy);
        chk($sformatf("mem_we[%0d]", s), we[s], expq[s].size() > 0);
        if (expq[s].size() > 0) begin
          chk($sformatf("mem_addr[%0d]", s), maddr[s], expq[s][0].a);
          chk($sformatf("mem_wdata[%0d]", s), mdata[s], expq[s][0].d);
        end else if (postrst[s]) begin
          chk($sformatf("rst_addr[%0d]", s), maddr[s], 0);
          chk($sformatf("rst_wdata[%0d]", s), mdata[s], 0);
        end
        chk($sformatf("busy[%0d]", s), busy[s], m0 != 0);
        chk($sformatf("done[%0d]", s), done[s], donem[s]);
        chk($sformatf("err[%0d]", s), err[s], errm[s]);
        chk($sformatf("written_count[%0d]", s), wc_act, wcnt[s]);
        if (done[s]) ndone[s]++;
      end
      if (rst) begin
        expq[s].delete();
        mode[s] = 0; acc[s] = 0; wcnt[s] = 0; basem[s] = 0;
        errm[s] = 0; donem[s] = 0; postrst[s] = 1;
      end else begin
        postrst[s] = 0;
        done_n = (m0 == 2) && (expq[s].size() == 0);
        if (m0 == 0 && start[s]) begin
          mode[s] = 1; basem[s] = longint'(base);
          acc[s] = 0; wcnt[s] = 0; errm[s] = 0;
        end
        if (mem_ready[s] && expq[s].size() > 0) begin
          void'(expq[s].pop_front());
          wcnt[s]++;
        end
        if (m0 == 1 && in_valid[s] && exp_rdy) begin
          x = s ? longint'(in_x[1:0]) : longint'(in_x);
          y = s ? longint'(in_y[0])   : longint'(in_y);
          c = s ? longint'(in_ch[0])  : longint'(in_ch);
          if (x < gw(s) && y < gh(s) && c < goc(s))
            expq[s].push_back('{a: AW'((basem[s] + (y * gw(s) + x) * goc(s) + c) & AMASK), d: din});
          else
            errm[s] = 1;
          acc[s]++;
          if (acc[s] == gw(s) * gh(s) * goc(s)) mode[s] = 2;
        end
        if (done_n) mode[s] = 0;
        donem[s] = done_n;
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic do_reset();
    rst = 1'b1; tick(2); rst = 1'b0;
  endtask

  task automatic do_start(input int s, input logic [AW-1:0] b);
    base = b; start[s] = 1'b1; tick(1); start[s] = 1'b0;
  endtask

  task automatic push(input int s, input int x, input int y, input int c, input logic [DW-1:0] d);
    bit a;
    in_x = 6'(x); in_y = 6'(y); in_ch = 5'(c); din = d;
    in_valid[s] = 1'b1;
    a = 0;
    for (int k = 0; k < 80 && !a; k++) begin
      @(negedge clk); a = rdy[s];
      @(posedge clk); #1;
    end
    if (!a) chk("push_timeout", 0, 1);
    in_valid[s] = 1'b0;
  endtask

  task automatic wait_done(input int s, input int budget);
    bit seen;
    seen = 0;
    for (int k = 0; k < budget && !seen; k++) begin
      @(negedge clk); seen = done[s];
    end
    chk($sformatf("done_seen[%0d]", s), seen, 1);
    chk($sformatf("busy_at_done[%0d]", s), busy[s], 0);
  endtask

  typedef struct {
    int s; logic [AW-1:0] b; int x, y, c; logic [DW-1:0] d; logic [AW-1:0] ea;
  } vec_t;

  vec_t vt [6];

  initial begin
    vt[0] = '{s: 0, b: 20'h00100, x: 2,  y: 1,  c: 5,  d: 32'hDEADBEEF, ea: 20'h00945};
    vt[1] = '{s: 0, b: 20'hFFFFF, x: 0,  y: 0,  c: 1,  d: 32'h12345678, ea: 20'h00000};
    vt[2] = '{s: 0, b: 20'h00000, x: 63, y: 63, c: 31, d: 32'hCAFEF00D, ea: 20'h1FFFF};
    vt[3] = '{s: 0, b: 20'hF0000, x: 0,  y: 2,  c: 0,  d: 32'h0000_0001, ea: 20'hF1000};
    vt[4] = '{s: 1, b: 20'h00010, x: 2,  y: 1,  c: 1,  d: 32'hA5A5A5A5, ea: 20'h0001B};
    vt[5] = '{s: 1, b: 20'hFFFFF, x: 1,  y: 0,  c: 0,  d: 32'hFFFFFFFF, ea: 20'h00001};

    tick(2);
    mon_en = 1;
    rst = 1'b0;

    // Single-beat address vectors, one layer start each
    for (int i = 0; i < 6; i++) begin
      int s;
      s = vt[i].s;
      do_reset();
      mr_mode[s] = 1;
      tick(1);
      do_start(s, vt[i].b);
      push(s, vt[i].x, vt[i].y, vt[i].c, vt[i].d);
      @(negedge clk);
      chk($sformatf("vec%0d_we", i), we[s], 1);
      chk($sformatf("vec%0d_addr", i), maddr[s], vt[i].ea);
      chk($sformatf("vec%0d_data", i), mdata[s], vt[i].d);
      chk($sformatf("vec%0d_err", i), err[s], 0);
      @(negedge clk);
      chk($sformatf("vec%0d_count", i), s ? longint'(wc1) : longint'(wc0), 1);
      @(posedge clk); #1;
    end

    // Backpressure: FIFO fills at 4, head held, then drains in order
    do_reset();
    mr_mode[0] = 0;
    do_start(0, 20'h00200);
    for (int i = 0; i < 4; i++) push(0, i, 0, 0, 32'hA0 + 32'(i));
    in_x = 6'd4; in_y = 6'd0; in_ch = 5'd0; din = 32'hA4; in_valid[0] = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("bp_ready_low", rdy[0], 0);
      chk("bp_head_addr", maddr[0], 20'h00200);
      chk("bp_head_data", mdata[0], 32'hA0);
      @(posedge clk); #1;
    end
    mr_mode[0] = 1;
    push(0, 4, 0, 0, 32'hA4);
    tick(8);
    chk("bp_total_written", wc0, 5);

    // Full 3x2x2 layer with alternating mem_ready
    do_reset();
    mr_mode[1] = 3;
    do_start(1, 20'h00000);
    ndone[1] = 0;
    for (int y = 0; y < 2; y++)
      for (int x = 0; x < 3; x++)
        for (int c = 0; c < 2; c++)
          push(1, x, y, c, 32'h100 + 32'((y * 3 + x) * 2 + c));
    @(negedge clk);
    chk("layer_ready_after_last", rdy[1], 0);
    wait_done(1, 60);
    chk("layer_count", wc1, 12);
    tick(4);
    chk("layer_done_pulses", ndone[1], 1);

    // Out-of-range beat: counted for the layer, never written, err sticky
    do_reset();
    mr_mode[1] = 1;
    do_start(1, 20'h00040);
    push(1, 3, 0, 0, 32'hBAD);
    @(negedge clk);
    chk("oor_no_we", we[1], 0);
    chk("oor_err", err[1], 1);
    @(posedge clk); #1;
    for (int i = 1; i < 12; i++) push(1, (i / 2) % 3, i / 6, i % 2, 32'h200 + 32'(i));
    wait_done(1, 60);
    chk("oor_count", wc1, 11);
    chk("oor_err_held", err[1], 1);
    @(posedge clk); #1;
    do_start(1, 20'h0);
    @(negedge clk);
    chk("oor_err_cleared", err[1], 0);
    @(posedge clk); #1;

    // Reset while beats are buffered
    do_reset();
    mr_mode[0] = 0;
    do_start(0, 20'h00300);
    for (int i = 0; i < 3; i++) push(0, i, 1, 2, 32'hC0 + 32'(i));
    rst = 1'b1; tick(1); rst = 1'b0;
    @(negedge clk);
    chk("rst_we", we[0], 0);
    chk("rst_busy", busy[0], 0);
    chk("rst_ready", rdy[0], 0);
    chk("rst_count", wc0, 0);
    @(posedge clk); #1;
    mr_mode[0] = 1;
    do_start(0, 20'h00123);
    push(0, 1, 0, 0, 32'hD00D);
    @(negedge clk);
    chk("rst_restart_addr", maddr[0], 20'h00143);
    @(negedge clk);
    chk("rst_restart_count", wc0, 1);
    @(posedge clk); #1;

    // Random layers on the small instance, random beats on the large one
    for (int l = 0; l < 6; l++) begin
      do_reset();
      mr_mode[1] = 2;
      do_start(1, 20'($urandom));
      for (int i = 0; i < 12; i++) begin
        push(1, $urandom_range(0, 3), $urandom_range(0, 1), $urandom_range(0, 1), $urandom);
        tick($urandom_range(0, 2));
      end
      wait_done(1, 80);
    end
    do_reset();
    mr_mode[0] = 2;
    do_start(0, 20'($urandom));
    for (int i = 0; i < 60; i++) begin
      if (i == 30) begin
        base = 20'($urandom); start[0] = 1'b1; tick(1); start[0] = 1'b0;
      end
      push(0, $urandom_range(0, 63), $urandom_range(0, 63), $urandom_range(0, 31), $urandom);
      tick($urandom_range(0, 1));
    end
    tick(30);
    chk("rand_big_drained", we[0], 0);
    chk("rand_big_count", wc0, 60);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
